// File: rtl/mbt_root_stage.sv
// rtl/mbt_root_stage.sv - MBitTree root stage: root-node bit extraction, child index, level-2 table read.
// Three register stages per channel; a root configured as a leaf bypasses the table.
module mbt_root_stage #(
    parameter int PACKET_WIDTH = 104,
    parameter int NODE_WIDTH   = 40,
    parameter int NUM_CH       = 2,
    parameter int NUM_EBITS    = 3,
    parameter int BIT_WIDTH    = 8,
    parameter int NODE_ADDR    = 9,
    parameter int L2_DEPTH     = 16,
    parameter int L2_AW        = 4,
    parameter logic [NODE_WIDTH-1:0] ROOT_INIT = 40'b000000000_00011111_00001101_00000010_111_000_0
) (
    input  logic                           clk,
    input  logic                           RSTn,
    input  logic [NUM_CH*PACKET_WIDTH-1:0] packet_in,
    input  logic [NUM_CH-1:0]              valid_in,
    output logic [NUM_CH*PACKET_WIDTH-1:0] packet_out,
    output logic [NUM_CH-1:0]              valid_out,
    output logic [NUM_CH*NODE_WIDTH-1:0]   node_out,
    output logic [NUM_CH-1:0]              matched_out,
    output logic [NUM_CH-1:0]              err_out,
    input  logic                           cfg_we,
    input  logic                           cfg_sel,
    input  logic [L2_AW-1:0]               cfg_addr,
    input  logic [NODE_WIDTH-1:0]          cfg_wdata
);

    localparam int MASK_LSB = 4;
    localparam int POS_LSB  = 4 + NUM_EBITS;
    localparam int BASE_LSB = NODE_WIDTH - NODE_ADDR;
    localparam int IDX_W    = NODE_ADDR + 1;

    localparam logic [IDX_W-1:0]        IDX_LIMIT  = IDX_W'(L2_DEPTH);
    localparam logic [L2_AW:0]          ADDR_LIMIT = (L2_AW + 1)'(L2_DEPTH);
    localparam logic [PACKET_WIDTH-1:0] HDR_ONE    = PACKET_WIDTH'(1);

    logic [NODE_WIDTH-1:0] r_root;
    logic [NODE_WIDTH-1:0] r_table [L2_DEPTH];

    logic [NUM_EBITS-1:0] w_mask;
    logic [NODE_ADDR-1:0] w_base;
    logic                 w_root_leaf;
    logic                 w_tbl_we;

    logic [NUM_CH-1:0][IDX_W-1:0] w_idx;
    logic [NUM_CH-1:0]            w_oor;

    logic [NUM_CH*PACKET_WIDTH-1:0] r_s1_pkt;
    logic [NUM_CH-1:0]              r_s1_vld;
    logic [NUM_CH-1:0][L2_AW-1:0]   r_s1_idx;
    logic [NUM_CH-1:0]              r_s1_err;
    logic                           r_s1_byp;
    logic [NODE_WIDTH-1:0]          r_s1_root;

    logic [NUM_CH*PACKET_WIDTH-1:0]    r_s2_pkt;
    logic [NUM_CH-1:0]                 r_s2_vld;
    logic [NUM_CH-1:0][NODE_WIDTH-1:0] r_s2_node;
    logic [NUM_CH-1:0]                 r_s2_err;

    assign w_mask      = r_root[MASK_LSB +: NUM_EBITS];
    assign w_base      = r_root[BASE_LSB +: NODE_ADDR];
    assign w_root_leaf = r_root[0];
    assign w_tbl_we    = cfg_we && cfg_sel && ({1'b0, cfg_addr} < ADDR_LIMIT);

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_root <= ROOT_INIT;
        end else if (cfg_we && !cfg_sel) begin
            r_root <= cfg_wdata;
        end
    end

    // Non-blocking update makes every same-edge S2 read return the old entry.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < L2_DEPTH; i++) begin
                r_table[i] <= '0;
            end
        end else if (w_tbl_we) begin
            r_table[cfg_addr] <= cfg_wdata;
        end
    end

    genvar gc, gi;
    for (gc = 0; gc < NUM_CH; gc++) begin : g_ch
        logic [PACKET_WIDTH-1:0] w_hdr;
        logic [NUM_EBITS-1:0]    w_e;

        assign w_hdr = packet_in[gc*PACKET_WIDTH +: PACKET_WIDTH];

        // A position past the header shifts the probe bit out, so that ebit reads 0.
        for (gi = 0; gi < NUM_EBITS; gi++) begin : g_bit
            assign w_e[gi] = |(w_hdr & (HDR_ONE << r_root[POS_LSB + gi*BIT_WIDTH +: BIT_WIDTH]));
        end

        assign w_idx[gc] = {1'b0, w_base} + IDX_W'(w_e & w_mask);
        assign w_oor[gc] = (w_idx[gc] >= IDX_LIMIT);
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_s1_pkt  <= '0;
            r_s1_vld  <= '0;
            r_s1_idx  <= '0;
            r_s1_err  <= '0;
            r_s1_byp  <= 1'b0;
            r_s1_root <= '0;
        end else begin
            r_s1_pkt  <= packet_in;
            r_s1_vld  <= valid_in;
            r_s1_byp  <= w_root_leaf;
            r_s1_root <= r_root;
            for (int c = 0; c < NUM_CH; c++) begin
                r_s1_idx[c] <= w_idx[c][L2_AW-1:0];
                r_s1_err[c] <= !w_root_leaf && w_oor[c];
            end
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_s2_pkt  <= '0;
            r_s2_vld  <= '0;
            r_s2_node <= '0;
            r_s2_err  <= '0;
        end else begin
            r_s2_pkt <= r_s1_pkt;
            r_s2_vld <= r_s1_vld;
            r_s2_err <= r_s1_err;
            for (int c = 0; c < NUM_CH; c++) begin
                if (r_s1_byp) begin
                    r_s2_node[c] <= r_s1_root;
                end else if (r_s1_err[c]) begin
                    r_s2_node[c] <= '0;
                end else begin
                    r_s2_node[c] <= r_table[r_s1_idx[c]];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            packet_out  <= '0;
            valid_out   <= '0;
            node_out    <= '0;
            matched_out <= '0;
            err_out     <= '0;
        end else begin
            packet_out <= r_s2_pkt;
            valid_out  <= r_s2_vld;
            for (int c = 0; c < NUM_CH; c++) begin
                node_out[c*NODE_WIDTH +: NODE_WIDTH] <= r_s2_vld[c] ? r_s2_node[c] : '0;
                matched_out[c] <= r_s2_vld[c] && r_s2_node[c][0];
                err_out[c]     <= r_s2_vld[c] && r_s2_err[c];
            end
        end
    end

endmodule
